// File: rtl/serial_tx_mod5.sv
// MSB-first serializer that also computes the transmitted word mod 5, bit by
// bit in the same order as the downstream mod-5 serial receiver sees it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a new word; in_ready=1
// S_SHIFT | one bit per non-held cycle; frame_end marks the LSB
// S_DONE  | one-cycle done pulse; rem_out/div5 already updated
module serial_tx_mod5 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] data_in,
    input  logic         hold,
    output logic         x,
    output logic         x_valid,
    output logic         frame_end,
    output logic         done,
    output logic [2:0]   rem_out,
    output logic         div5
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_shift;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_rem;
    logic [2:0]      r_rem_out;
    logic            r_div5;

    logic            w_accept;
    logic            w_cnt_zero;
    logic [3:0]      w_r2x;
    logic [2:0]      w_rem_nxt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (frame_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        x_valid   = (r_state == S_SHIFT) & ~hold;
        frame_end = (r_state == S_SHIFT) & ~hold & w_cnt_zero;
        done      = (r_state == S_DONE);
    end

    assign w_accept   = in_valid & in_ready;
    assign w_cnt_zero = (r_cnt == '0);

    // Horner step on the outgoing bit: r' = (2r + x) mod 5, never above 9
    assign w_r2x     = {r_rem, 1'b0} + {3'b000, r_shift[W-1]};
    assign w_rem_nxt = (w_r2x >= 4'd5) ? 3'(w_r2x - 4'd5) : w_r2x[2:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_rem_out <= '0;
            r_div5    <= 1'b0;
        end else if (w_accept) begin
            r_shift <= data_in;
            r_cnt   <= CNT_LOAD;
            r_rem   <= '0;
        end else if (x_valid) begin
            r_shift <= {r_shift[W-2:0], 1'b0};
            r_rem   <= w_rem_nxt;
            if (w_cnt_zero) begin
                r_rem_out <= w_rem_nxt;
                r_div5    <= (w_rem_nxt == 3'd0);
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign x       = r_shift[W-1];
    assign rem_out = r_rem_out;
    assign div5    = r_div5;

endmodule

// File: tb/tb_serial_tx_mod5.sv
// Directed bench for serial_tx_mod5 (W=8): framing, hold, back-to-back,
// mid-frame reset and a full 0..255 sweep through a mod-5 receiver model.
module tb_serial_tx_mod5;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic       hold;
    logic       x;
    logic       x_valid;
    logic       frame_end;
    logic       done;
    logic [2:0] rem_out;
    logic       div5;

    int n_checks = 0;
    int n_fail   = 0;

    serial_tx_mod5 #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .hold      (hold),
        .x         (x),
        .x_valid   (x_valid),
        .frame_end (frame_end),
        .done      (done),
        .rem_out   (rem_out),
        .div5      (div5)
    );

    always #5 clk = ~clk;

    // Drives one frame and records what the serial side produced; no checks here.
    task automatic run_frame(input logic [7:0] d, input int hold_at, input int hold_len,
                             output logic [7:0] bits, output int nbits, output int fe_pos,
                             output int done_cyc, output int busy_ready, output int hold_xv,
                             output logic hold_x, output bit tmo);
        int held;
        bit fin;
        bits = '0; nbits = 0; fe_pos = -1; done_cyc = -1; busy_ready = 0;
        hold_xv = 0; hold_x = 1'b0; tmo = 1'b0; held = 0; fin = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        in_valid = 1'b1;
        data_in  = d;
        for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
            data_in  = '0;
            if (nbits == hold_at && held < hold_len) begin
                hold = 1'b1;
                held++;
            end else begin
                hold = 1'b0;
            end
            #1;
            if (in_ready) busy_ready++;
            if (hold) begin
                if (x_valid) hold_xv++;
                hold_x = x;
            end
            if (x_valid) begin
                bits = {bits[6:0], x};
                if (frame_end) fe_pos = nbits;
                nbits++;
            end
            if (done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
        end
        hold = 1'b0;
        if (!fin) tmo = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; data_in = '0; hold = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (x !== 1'b0)         begin n_fail++; $display("FAIL reset_x: got %b expected 0", x); end
        n_checks++; if (x_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_x_valid: got %b expected 0", x_valid); end
        n_checks++; if (frame_end !== 1'b0) begin n_fail++; $display("FAIL reset_frame_end: got %b expected 0", frame_end); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (rem_out !== 3'd0)   begin n_fail++; $display("FAIL reset_rem_out: got %0d expected 0", rem_out); end
        n_checks++; if (div5 !== 1'b0)      begin n_fail++; $display("FAIL reset_div5: got %b expected 0", div5); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_frame_0a();
        logic [7:0] bits; int nb, fe, dc, br, hxv; logic hx; bit tmo;
        run_frame(8'h0A, -1, 0, bits, nb, fe, dc, br, hxv, hx, tmo);
        n_checks++; if (tmo)             begin n_fail++; $display("FAIL f0a_timeout: got no done expected done"); end
        n_checks++; if (bits !== 8'h0A)  begin n_fail++; $display("FAIL f0a_bits: got %h expected 0a", bits); end
        n_checks++; if (nb != 8)         begin n_fail++; $display("FAIL f0a_nbits: got %0d expected 8", nb); end
        n_checks++; if (fe != 7)         begin n_fail++; $display("FAIL f0a_frame_end_pos: got %0d expected 7", fe); end
        n_checks++; if (dc != 9)         begin n_fail++; $display("FAIL f0a_latency: got %0d expected 9", dc); end
        n_checks++; if (br != 0)         begin n_fail++; $display("FAIL f0a_busy_ready: got %0d expected 0", br); end
        n_checks++; if (rem_out !== 3'd0) begin n_fail++; $display("FAIL f0a_rem_out: got %0d expected 0", rem_out); end
        n_checks++; if (div5 !== 1'b1)   begin n_fail++; $display("FAIL f0a_div5: got %b expected 1", div5); end
        @(negedge clk);
        #1;
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL f0a_done_width: got %b expected 0", done); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL f0a_back_idle: got %b expected 1", in_ready); end
        n_checks++; if (rem_out !== 3'd0) begin n_fail++; $display("FAIL f0a_rem_held: got %0d expected 0", rem_out); end
    endtask

    task automatic test_remainders();
        logic [7:0] vec [3]  = '{8'h07, 8'hFE, 8'hFF};
        logic [2:0] erem [3] = '{3'd2, 3'd4, 3'd0};
        logic       ediv [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] bits; int nb, fe, dc, br, hxv; logic hx; bit tmo;
        for (int i = 0; i < 3; i++) begin
            run_frame(vec[i], -1, 0, bits, nb, fe, dc, br, hxv, hx, tmo);
            n_checks++; if (tmo)              begin n_fail++; $display("FAIL rem_timeout[%0d]: got no done expected done", i); end
            n_checks++; if (bits !== vec[i])  begin n_fail++; $display("FAIL rem_bits[%0d]: got %h expected %h", i, bits, vec[i]); end
            n_checks++; if (rem_out !== erem[i]) begin n_fail++; $display("FAIL rem_value[%0d]: got %0d expected %0d", i, rem_out, erem[i]); end
            n_checks++; if (div5 !== ediv[i]) begin n_fail++; $display("FAIL rem_div5[%0d]: got %b expected %b", i, div5, ediv[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int acc1 = -1, acc2 = -1, nd = 0, busy = 0, d1 = -1, d2 = -1;
        logic [2:0] r1 = 3'd7, r2 = 3'd7;
        logic v1 = 1'bx, v2 = 1'bx;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 8'h07;
        for (int cyc = 0; cyc < 40 && nd < 2; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (acc1 >= 0) data_in = 8'h0A;
            if (acc2 >= 0) in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) begin
                if (acc1 < 0) acc1 = cyc;
                else if (acc2 < 0) acc2 = cyc;
            end
            if (acc1 >= 0 && cyc > acc1 && cyc <= acc1 + 9 && in_ready) busy++;
            if (done) begin
                nd++;
                if (nd == 1) begin d1 = cyc; r1 = rem_out; v1 = div5; end
                else begin d2 = cyc; r2 = rem_out; v2 = div5; end
            end
        end
        in_valid = 1'b0;
        n_checks++; if (acc1 != 0)   begin n_fail++; $display("FAIL b2b_first_accept: got %0d expected 0", acc1); end
        n_checks++; if (acc2 != 10)  begin n_fail++; $display("FAIL b2b_second_accept: got %0d expected 10", acc2); end
        n_checks++; if (busy != 0)   begin n_fail++; $display("FAIL b2b_ready_while_busy: got %0d expected 0", busy); end
        n_checks++; if (d1 != 9)     begin n_fail++; $display("FAIL b2b_done1: got %0d expected 9", d1); end
        n_checks++; if (d2 != 19)    begin n_fail++; $display("FAIL b2b_done2: got %0d expected 19", d2); end
        n_checks++; if (r1 !== 3'd2 || v1 !== 1'b0) begin n_fail++; $display("FAIL b2b_word1: got rem %0d div5 %b expected rem 2 div5 0", r1, v1); end
        n_checks++; if (r2 !== 3'd0 || v2 !== 1'b1) begin n_fail++; $display("FAIL b2b_word2: got rem %0d div5 %b expected rem 0 div5 1", r2, v2); end
    endtask

    task automatic test_hold();
        logic [7:0] bits; int nb, fe, dc, br, hxv; logic hx; bit tmo;
        run_frame(8'hB5, 3, 3, bits, nb, fe, dc, br, hxv, hx, tmo);
        n_checks++; if (tmo)             begin n_fail++; $display("FAIL hold_timeout: got no done expected done"); end
        n_checks++; if (bits !== 8'hB5)  begin n_fail++; $display("FAIL hold_bits: got %h expected b5", bits); end
        n_checks++; if (hxv != 0)        begin n_fail++; $display("FAIL hold_x_valid: got %0d valid cycles expected 0", hxv); end
        n_checks++; if (hx !== 1'b1)     begin n_fail++; $display("FAIL hold_x_frozen: got %b expected 1", hx); end
        n_checks++; if (dc != 12)        begin n_fail++; $display("FAIL hold_latency: got %0d expected 12", dc); end
        n_checks++; if (rem_out !== 3'd1) begin n_fail++; $display("FAIL hold_rem_out: got %0d expected 1", rem_out); end
        n_checks++; if (div5 !== 1'b0)   begin n_fail++; $display("FAIL hold_div5: got %b expected 0", div5); end
    endtask

    task automatic test_reset_midframe();
        int nb = 0, dones = 0;
        logic [7:0] bits; int nbt, fe, dc, br, hxv; logic hx; bit tmo;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 8'h0A;
        for (int cyc = 0; cyc < 20 && nb < 4; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (x_valid) nb++;
        end
        n_checks++; if (nb != 4) begin n_fail++; $display("FAIL mid_reach_bit4: got %0d bits expected 4", nb); end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if ({x, x_valid, frame_end, done, in_ready} !== 5'b00001)
            begin n_fail++; $display("FAIL mid_reset_outputs: got %b expected 00001", {x, x_valid, frame_end, done, in_ready}); end
        n_checks++; if (rem_out !== 3'd0 || div5 !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset_result: got rem %0d div5 %b expected rem 0 div5 0", rem_out, div5); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (done) dones++;
        end
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (done || !in_ready || x_valid) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d busy/done cycles expected 0", dones); end
        run_frame(8'h05, -1, 0, bits, nbt, fe, dc, br, hxv, hx, tmo);
        n_checks++; if (tmo || bits !== 8'h05) begin n_fail++; $display("FAIL mid_next_frame: got bits %h expected 05", bits); end
        n_checks++; if (rem_out !== 3'd0 || div5 !== 1'b1)
            begin n_fail++; $display("FAIL mid_next_result: got rem %0d div5 %b expected rem 0 div5 1", rem_out, div5); end
    endtask

    task automatic test_receiver_sweep();
        logic [7:0] bits; int nb, fe, dc, br, hxv; logic hx; bit tmo;
        int rx;
        for (int v = 0; v < 256; v++) begin
            run_frame(8'(v), -1, 0, bits, nb, fe, dc, br, hxv, hx, tmo);
            rx = 0;
            for (int i = 7; i >= 0; i--) rx = (2 * rx + int'(bits[i])) % 5;
            n_checks++; if (tmo || nb != 8) begin n_fail++; $display("FAIL sweep_frame[%0d]: got %0d bits expected 8", v, nb); end
            n_checks++; if (div5 !== (rx == 0)) begin n_fail++; $display("FAIL sweep_div5[%0d]: got %b expected %b", v, div5, rx == 0); end
            n_checks++; if (rem_out !== 3'(v % 5)) begin n_fail++; $display("FAIL sweep_rem[%0d]: got %0d expected %0d", v, rem_out, v % 5); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_0a();
        test_remainders();
        test_back_to_back();
        test_hold();
        test_reset_midframe();
        test_receiver_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx_mod5.md
SERIAL_TX_MOD5 -- requirements
Module: serial_tx_mod5

Interface
REQ-001 Parameter: W, default 8, width of the parallel word serialized per frame (legal W >= 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-low.
REQ-004 in_valid  input  1  parallel word offered on data_in.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 data_in  input  W  unsigned word to transmit, MSB first.
REQ-007 hold  input  1  downstream stall; freezes shifting while high.
REQ-008 x  output  1  serial data bit, MSB first, the input format of the team's mod-5 serial receiver.
REQ-009 x_valid  output  1  x carries a valid bit this cycle.
REQ-010 frame_end  output  1  current x is the last (LSB) bit of the frame.
REQ-011 done  output  1  one-cycle pulse after the last bit has been sent.
REQ-012 rem_out  output  3  data_in mod 5 of the last completed frame, range 0..4.
REQ-013 div5  output  1  rem_out == 0 for the last completed frame.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-016 On accept, the block SHALL load data_in into a W-bit shift register, set the bit counter to W-1, clear the running remainder r to 0, and go to SHIFT.
REQ-017 In IDLE without accept, the block SHALL remain in IDLE; data_in is don't-care.
REQ-018 x SHALL always equal shift register bit W-1, a registered value.
REQ-019 x_valid SHALL be (state==SHIFT) & ~hold.
REQ-020 On each edge with x_valid=1: shift left by one, zero-fill the LSB, decrement the counter, and update r <= (2*r + x) mod 5, computed as 2*r+x minus 5 when >= 5 (4-bit intermediate).
REQ-021 With hold=1 in SHIFT, shift register, counter, r and state SHALL hold; x keeps its value.
REQ-022 frame_end SHALL be x_valid & (counter==0).
REQ-023 On an edge with frame_end=1: the FSM goes to DONE, rem_out <= final r including the LSB, and div5 <= (final r == 0).
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally; hold is ignored in DONE.
REQ-025 in_valid SHALL be ignored outside IDLE; a word is never captured while busy, and a word offered in DONE is accepted on the following IDLE cycle if still valid.
REQ-026 Latency: accept edge to done=1 SHALL be W+1 cycles with hold=0; each hold cycle adds one.
REQ-027 Minimum frame spacing: accept, W SHIFT cycles, 1 DONE cycle, 1 IDLE cycle, so consecutive accepts are W+2 cycles apart.
REQ-028 rem_out and div5 SHALL hold their values until the next frame completes.

Reset
REQ-029 While rst=0, the block SHALL asynchronously force: state IDLE, shift register 0, counter 0, r 0, rem_out 0, div5 0.
REQ-030 Output values during reset SHALL be: x=0, x_valid=0, frame_end=0, done=0, in_ready=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no done pulse; after release, the block SHALL be in IDLE and ready.

Verification
REQ-032 Send data_in=8'h0A, hold=0 -> x sequence 0,0,0,0,1,0,1,0 on 8 consecutive x_valid cycles, frame_end on the 8th, done on the next cycle, rem_out=0, div5=1.
REQ-033 Send 8'h07 -> rem_out=2, div5=0; send 8'hFE -> rem_out=4, div5=0; send 8'hFF -> rem_out=0, div5=1.
REQ-034 Send 8'hB5 with hold=1 for 3 cycles after the 3rd bit -> x frozen at bit 4, x_valid=0 during hold, done 12 cycles after accept, rem_out=1.
REQ-035 Hold in_valid=1 continuously with two words -> second accept exactly 10 cycles after the first, no word lost, in_ready=0 from SHIFT through DONE.
REQ-036 Assert rst=0 after the 4th bit of 8'h0A -> outputs take reset values immediately, no done pulse; the next frame 8'h05 completes with rem_out=0.
REQ-037 Loop x/x_valid into the mod-5 receiver, with the receiver reset before each frame and clocked only on x_valid cycles -> receiver divisible flag equals div5 for all 256 values.
